frame_unpacker: RTL
===================

# frame_unpacker

Downstream consumer of the UART frame receiver's byte stream. It takes the receiver's length byte and the payload byte strobes that follow it, then parses them into a command/sequence header, 16-bit little-endian data words and a 16-bit checksum. Data words are buffered in a small FIFO behind a valid/ready handshake. Per-frame status is reported on a completion pulse.

## Interface
- DEPTH, 8, FIFO depth in words; power of two, ≥2.
- TIMEOUT, 4096, idle clock cycles tolerated between bytes inside a frame.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state.
- byte_in  in  8  byte from the receiver's outstream.
- byte_valid  in  1  single-cycle strobe from the receiver's infodump; byte_in is valid this cycle.
- word_out  out  16  FIFO head data word.
- word_last  out  1  FIFO head is the final data word of its frame.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts head; pop when word_valid && word_ready.
- cmd  out  8  CMD byte of the last completed frame.
- seq  out  8  SEQ byte of the last completed frame.
- frame_done  out  1  one-cycle pulse at the end of a frame, good or bad.
- frame_ok  out  1  last frame had no error; held until the next frame_done.
- err_checksum, err_overflow, err_timeout, err_length  out  1 each  error flags for the last frame; held until the next frame_done.
- busy  out  1  FSM not in IDLE.

## Operation
- Frame byte order: L, CMD, SEQ, L data words (low byte then high byte), CHK_LO, CHK_HI. This gives 2L+4 bytes after L, matching the receiver's count.
- L is valid in the range 0..MAXLEN (125). L ≥ 126 sets err_length and the FSM enters SKIP.
- Checksum: 16-bit sum, mod 2^16, of L, CMD, SEQ and every data byte, each byte zero-extended. The result is compared against {CHK_HI, CHK_LO}.
- FSM states: IDLE, CMD, SEQ, D_LO, D_HI, CHK_LO, CHK_HI, SKIP. Each transition below consumes one byte_valid.
  - IDLE→CMD: L loaded into an 8-bit words-remaining counter; sum = L.
  - CMD→SEQ.
  - SEQ→D_LO if L>0, else SEQ→CHK_LO.
  - D_LO→D_HI.
  - D_HI→D_LO while remaining>1, else D_HI→CHK_LO; remaining decrements on each D_HI.
  - CHK_LO→CHK_HI.
  - CHK_HI→IDLE with frame_done.
- SKIP discards bytes and exits only through the timeout.
- Data words stream into the FIFO as they complete; they are not held for the checksum. The consumer discards a frame's words when frame_ok=0. word_last is stored alongside each word, set on the word where remaining==1.
- FIFO full on push: the word is dropped and err_overflow is latched for the frame. A push in the same cycle as a pop from a full FIFO is accepted.
- Timeout: an idle counter clears on each byte_valid. In any non-IDLE state, reaching TIMEOUT raises err_timeout (or keeps err_length when in SKIP), pulses frame_done and returns to IDLE. The counter saturates and does not wrap.
- frame_ok = no error flag set. cmd and seq update at frame_done only when the frame reached CHK_HI.
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0.

## Timing
- byte_valid strobes are spaced by at least one UART byte time; back-to-back strobes (every cycle) must also work.
- Word push occurs on the cycle of the D_HI strobe. word_valid rises 1 cycle later if the FIFO was empty.
- frame_done, frame_ok and err_* are registered and update 1 cycle after the CHK_HI strobe or after the timeout cycle.
- A byte_valid in the cycle the FSM sits in IDLE after a frame is taken as the next frame's L. No dead cycle is required.
- Reset asserted mid-frame: immediate return to IDLE, FIFO flushed, no frame_done.
- word_ready is ignored while word_valid=0.

## Structure
- Package frame_pkg holds: the state enum, MAXLEN=125, the checksum width (16) and the status flag bit positions.
- Sub-module word_fifo: DEPTH×17 storage (word + last), pointers of width clog2(DEPTH), a count of width clog2(DEPTH)+1, and full/empty outputs.
- Top level holds the FSM, checksum accumulator, remaining counter, idle counter and status registers.

## Test plan
- Good frame, word_ready=1: bytes 02 10 01 34 12 EF BE 06 02 → FIFO outputs 0x1234 (last=0) then 0xBEEF (last=1). frame_done with frame_ok=1, cmd=0x10, seq=0x01.
- Same frame with CHK_HI=03 → both words still delivered; frame_ok=0, err_checksum=1.
- L=0: bytes 00 22 05 27 00 → no words, frame_ok=1, cmd=0x22.
- word_ready=0, DEPTH=8, L=10 with a correct checksum → 8 words held, 2 dropped. err_overflow=1, the 8th word has last=0.
- Strobe 03 10 01 AA, then no bytes for TIMEOUT cycles → frame_done, err_timeout=1, busy=0. The next frame parses normally.
- L=0x7E (126) → err_length=1 at timeout. Separately, reset pulled low mid-data → FIFO empty, outputs 0, no frame_done.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the frame unpacker: FSM encoding, payload
// limits, checksum width and status flag positions.
package frame_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_SEQ,
      S_D_LO,
      S_D_HI,
      S_CHK_LO,
      S_CHK_HI,
      S_SKIP
   } state_t;

   localparam int MAXLEN = 125;
   localparam int CSUM_W = 16;

   localparam int ERR_CHECKSUM = 0;
   localparam int ERR_OVERFLOW = 1;
   localparam int ERR_TIMEOUT  = 2;
   localparam int ERR_LENGTH   = 3;
   localparam int N_ERR        = 4;

endpackage

// File: rtl/frame_unpacker_if.sv
// Byte-in / word-out / status bundle between the frame unpacker and its
// neighbours. slave is the unpacker side, master the producer/consumer side.
interface frame_unpacker_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic [15:0] word_out;
   logic        word_last;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  cmd;
   logic [7:0]  seq;
   logic        frame_done;
   logic        frame_ok;
   logic        err_checksum;
   logic        err_overflow;
   logic        err_timeout;
   logic        err_length;
   logic        busy;

   modport slave (
      input  byte_in, byte_valid, word_ready,
      output word_out, word_last, word_valid, cmd, seq, frame_done, frame_ok,
             err_checksum, err_overflow, err_timeout, err_length, busy
   );

   modport master (
      output byte_in, byte_valid, word_ready,
      input  word_out, word_last, word_valid, cmd, seq, frame_done, frame_ok,
             err_checksum, err_overflow, err_timeout, err_length, busy
   );
endinterface

// File: rtl/word_fifo.sv
// Small synchronous FIFO for {last, word} entries. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module word_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_cnt == CNT_FULL);
   assign o_empty   = (r_cnt == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   // Stale storage is masked so the head reads zero whenever the FIFO is empty.
   assign o_data    = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PTR_ONE;
         if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/frame_unpacker.sv
// Parses L/CMD/SEQ/data/checksum byte frames into 16-bit words (FIFO buffered)
// and reports per-frame status on a one-cycle frame_done pulse.
//
//   state    | meaning
//   S_IDLE   | waiting for length byte L
//   S_CMD    | expecting CMD byte
//   S_SEQ    | expecting SEQ byte
//   S_D_LO   | expecting low byte of a data word
//   S_D_HI   | expecting high byte; word pushed to FIFO
//   S_CHK_LO | expecting checksum low byte
//   S_CHK_HI | expecting checksum high byte; frame completes
//   S_SKIP   | bad length, discarding until idle timeout
module frame_unpacker
   import frame_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic            clk,
   input  logic            rst_n,
   frame_unpacker_if.slave bus
);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] TMO_LAST = IW'(TIMEOUT - 1);
   localparam logic [IW-1:0] TMO_SAT  = IW'(TIMEOUT);
   localparam logic [IW-1:0] IDLE_ONE = IW'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_rem;
   logic [7:0]        r_lo;
   logic [7:0]        r_chk_lo;
   logic [7:0]        r_cmd_cur;
   logic [7:0]        r_seq_cur;
   logic [7:0]        r_cmd;
   logic [7:0]        r_seq;
   logic [CSUM_W-1:0] r_sum;
   logic [IW-1:0]     r_idle;
   logic [N_ERR-1:0]  r_err_cur;
   logic [N_ERR-1:0]  r_err;
   logic [N_ERR-1:0]  w_err_fin;
   logic              r_done;
   logic              r_ok;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_tmo;
   logic              w_fin;
   logic              w_sum_bad;
   logic [16:0]       w_fifo_out;

   assign w_sum_bad = ({bus.byte_in, r_chk_lo} != r_sum);
   assign w_pop     = !w_empty && bus.word_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_fin       = 1'b0;
      w_tmo       = 1'b0;
      if (r_state != S_IDLE && !bus.byte_valid && r_idle == TMO_LAST) begin
         w_tmo       = 1'b1;
         w_state_nxt = S_IDLE;
      end else if (bus.byte_valid) begin
         case (r_state)
            S_IDLE:   w_state_nxt = (bus.byte_in > 8'(MAXLEN)) ? S_SKIP : S_CMD;
            S_CMD:    w_state_nxt = S_SEQ;
            S_SEQ:    w_state_nxt = (r_rem != 8'd0) ? S_D_LO : S_CHK_LO;
            S_D_LO:   w_state_nxt = S_D_HI;
            S_D_HI: begin
               w_push      = 1'b1;
               w_state_nxt = (r_rem > 8'd1) ? S_D_LO : S_CHK_LO;
            end
            S_CHK_LO: w_state_nxt = S_CHK_HI;
            S_CHK_HI: begin
               w_fin       = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = r_state;
         endcase
      end
   end

   // A timeout while skipping an over-length frame reports only the length error.
   always_comb begin
      w_err_fin = r_err_cur;
      if (w_fin && w_sum_bad)          w_err_fin[ERR_CHECKSUM] = 1'b1;
      if (w_tmo && r_state != S_SKIP)  w_err_fin[ERR_TIMEOUT]  = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rem     <= '0;
         r_lo      <= '0;
         r_chk_lo  <= '0;
         r_cmd_cur <= '0;
         r_seq_cur <= '0;
         r_cmd     <= '0;
         r_seq     <= '0;
         r_sum     <= '0;
         r_idle    <= '0;
         r_err_cur <= '0;
         r_err     <= '0;
         r_done    <= 1'b0;
         r_ok      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_tmo || w_fin;

         if (bus.byte_valid || r_state == S_IDLE) r_idle <= '0;
         else if (r_idle != TMO_SAT)              r_idle <= r_idle + IDLE_ONE;

         if (bus.byte_valid) begin
            case (r_state)
               S_IDLE: begin
                  r_rem     <= bus.byte_in;
                  r_sum     <= CSUM_W'(bus.byte_in);
                  r_err_cur <= '0;
                  if (bus.byte_in > 8'(MAXLEN)) r_err_cur[ERR_LENGTH] <= 1'b1;
               end
               S_CMD: begin
                  r_cmd_cur <= bus.byte_in;
                  r_sum     <= r_sum + CSUM_W'(bus.byte_in);
               end
               S_SEQ: begin
                  r_seq_cur <= bus.byte_in;
                  r_sum     <= r_sum + CSUM_W'(bus.byte_in);
               end
               S_D_LO: begin
                  r_lo  <= bus.byte_in;
                  r_sum <= r_sum + CSUM_W'(bus.byte_in);
               end
               S_D_HI: begin
                  r_rem <= r_rem - 8'd1;
                  r_sum <= r_sum + CSUM_W'(bus.byte_in);
               end
               S_CHK_LO: r_chk_lo <= bus.byte_in;
               default: ;
            endcase
         end

         if (w_push && w_full && !w_pop) r_err_cur[ERR_OVERFLOW] <= 1'b1;

         if (w_tmo || w_fin) begin
            r_err <= w_err_fin;
            r_ok  <= (w_err_fin == '0);
         end
         if (w_fin) begin
            r_cmd <= r_cmd_cur;
            r_seq <= r_seq_cur;
         end
      end
   end

   word_fifo #(.DEPTH(DEPTH), .W(17)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({(r_rem == 8'd1), bus.byte_in, r_lo}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.word_out     = w_fifo_out[15:0];
   assign bus.word_last    = w_fifo_out[16];
   assign bus.word_valid   = !w_empty;
   assign bus.cmd          = r_cmd;
   assign bus.seq          = r_seq;
   assign bus.frame_done   = r_done;
   assign bus.frame_ok     = r_ok;
   assign bus.err_checksum = r_err[ERR_CHECKSUM];
   assign bus.err_overflow = r_err[ERR_OVERFLOW];
   assign bus.err_timeout  = r_err[ERR_TIMEOUT];
   assign bus.err_length   = r_err[ERR_LENGTH];
   assign bus.busy         = (r_state != S_IDLE);
endmodule
